// File: rtl/fir_64_seq_pkg.sv
// Shared definitions for the fir_64 frame sequencer: fir_64 operation codes and sequencer states.
package fir_64_seq_pkg;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {
    CLR    = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    RD_REQ = 3'd3,
    RD_CAP = 3'd4,
    OUT    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/fir_64_seq_watchdog.sv
// Run-phase watchdog: counts enabled cycles and flags the cycle on which the count hits TIMEOUT-1.
module fir_watchdog #(
  parameter int TIMEOUT = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam logic [31:0] EXPIRE_AT = 32'(TIMEOUT - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // clear has priority so a new frame always starts from zero
  always_comb begin
    if (clr_i) begin
      cnt_d = 32'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/fir_64_seq.sv
// Frame sequencer around fir_64: loads a frame from a valid/ready stream, runs the filter,
// then reads each result back and presents it on a valid/ready output stream.
module fir_64_seq
  import fir_64_seq_pkg::*;
#(
  parameter int SIGNAL_LENGTH = 1000,
  parameter int COEFS_LENGTH  = 100,
  parameter int TIMEOUT       = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err,
  output logic        fir_reset,
  output logic [31:0] fir_addr,
  output logic [63:0] fir_x,
  output logic [1:0]  fir_operation,
  input  logic [63:0] fir_y,
  input  logic        fir_done
);

  localparam logic [31:0] LAST_IDX = 32'(SIGNAL_LENGTH - 1);
  // Nominal filter run length; TIMEOUT should comfortably exceed it.
  localparam int unused_nominal_run = SIGNAL_LENGTH * (4 * COEFS_LENGTH + 1) + 1;

  seq_state_t  state_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] rd_cnt_q;
  logic [63:0] out_data_q;
  logic        out_valid_q;
  logic        err_q;
  logic        wd_expire;

  fir_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (state_q == RUN),
    .clr_i   (state_q == CLR),
    .expire_o(wd_expire)
  );

  // FIR-side controls; everything is forced idle while reset is held low
  always_comb begin
    fir_addr      = 32'd0;
    fir_x         = 64'd0;
    fir_operation = OP_IDLE;
    in_ready      = 1'b0;
    if (!reset) begin
      fir_operation = OP_IDLE;
    end else begin
      case (state_q)
        LOAD: begin
          in_ready      = 1'b1;
          fir_addr      = wr_cnt_q;
          fir_x         = in_data;
          fir_operation = in_valid ? OP_WRITE : OP_IDLE;
        end
        RUN:     fir_operation = OP_RUN;
        RD_REQ: begin
          fir_operation = OP_READ;
          fir_addr      = rd_cnt_q;
        end
        default: fir_operation = OP_IDLE;
      endcase
    end
  end

  // Sequencer FSM with registered result stream and sticky watchdog error
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CLR;
      wr_cnt_q    <= 32'd0;
      rd_cnt_q    <= 32'd0;
      out_data_q  <= 64'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        CLR: begin
          wr_cnt_q <= 32'd0;
          rd_cnt_q <= 32'd0;
          state_q  <= LOAD;
        end
        LOAD: begin
          if (in_valid) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
            if (wr_cnt_q == LAST_IDX) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // done wins over an expiry on the same cycle
          if (fir_done) begin
            state_q <= RD_REQ;
          end else if (wd_expire) begin
            err_q   <= 1'b1;
            state_q <= CLR;
          end
        end
        RD_REQ: state_q <= RD_CAP;
        RD_CAP: begin
          out_data_q  <= fir_y;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rd_cnt_q    <= rd_cnt_q + 32'd1;
            state_q     <= (rd_cnt_q == LAST_IDX) ? CLR : RD_REQ;
          end
        end
        default: state_q <= CLR;
      endcase
    end
  end

  assign fir_reset = (state_q == CLR) || !reset;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (rd_cnt_q == LAST_IDX);
  assign busy      = !((state_q == LOAD) && (wr_cnt_q == 32'd0));
  assign err       = err_q;

endmodule
